// File: rtl/parport_pkg.sv
// Shared types, default timing and width helpers for the parallel-port sequencer.
package parport_pkg;

  // Sequencer states for one Centronics byte transfer
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_WAIT   = 3'd4
  } state_e;

  // Default timing in clk32 cycles
  localparam int unsigned DEF_FIFO_DEPTH  = 16;
  localparam int unsigned DEF_SETUP_CYC   = 16;
  localparam int unsigned DEF_STROBE_CYC  = 32;
  localparam int unsigned DEF_HOLD_CYC    = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 32000000;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Largest of three timing values
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/parport_fifo.sv
// Byte FIFO with registered level, not-full and empty flags.
module parport_fifo
  import parport_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk32,
  input  logic                       reset_n,
  input  logic [7:0]                 wr_data,
  input  logic                       push,
  input  logic                       pop,
  output logic [7:0]                 rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       not_full,
  output logic                       empty,
  output logic                       empty_next_c
);

  localparam int unsigned AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          not_full_q, not_full_d;
  logic          empty_q, empty_d;
  logic          push_ok, pop_ok;

  // Next pointers, level and flags; writes are refused when full
  always_comb begin
    push_ok  = push && not_full_q;
    pop_ok   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
    if (pop_ok)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = LW'(level_q + 1'b1);
      2'b01:   level_d = LW'(level_q - 1'b1);
      default: level_d = level_q;
    endcase
    not_full_d = (level_d != LW'(DEPTH));
    empty_d    = (level_d == '0);
  end

  // Pointer, level and flag registers
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      not_full_q <= 1'b1;
      empty_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      not_full_q <= not_full_d;
      empty_q    <= empty_d;
    end
  end

  // Storage array, contents are don't-care until written
  always_ff @(posedge clk32) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data      = mem[rd_ptr_q];
  assign level        = level_q;
  assign not_full     = not_full_q;
  assign empty        = empty_q;
  assign empty_next_c = empty_d;

endmodule

// File: rtl/parport_seq.sv
// Centronics output sequencer: byte FIFO, BUSY-paced setup/strobe/hold timing
// and sticky BUSY timeout. Optional ACK pacing with macro PARPORT_ACK_EN.
module parport_seq
  import parport_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC  = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          clk32,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          busy_in,
`ifdef PARPORT_ACK_EN
  input  logic                          ack_n,
`endif
  output logic [7:0]                    data_out,
  output logic                          data_oe,
  output logic                          strobe_out,
  output logic                          strobe_oe,
  output logic                          idle,
  output logic                          timeout_err,
  input  logic                          clr_err
);

  localparam int unsigned CW = cnt_width(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC));
  localparam int unsigned TW = cnt_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    data_q, data_d;
  logic          strobe_q, strobe_d;
  logic          oe_q, oe_d;
  logic          idle_q, idle_d;
  logic          err_q, err_d;
  logic          busy_meta_q, busy_s_q;
  logic          pop_c;
  logic          ack_ok;

  logic [7:0]    fifo_rd;
  logic          fifo_not_full;
  logic          fifo_empty;
  logic          fifo_empty_next;

  parport_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk32        (clk32),
    .reset_n      (reset_n),
    .wr_data      (wr_data),
    .push         (wr_valid),
    .pop          (pop_c),
    .rd_data      (fifo_rd),
    .level        (fifo_level),
    .not_full     (fifo_not_full),
    .empty        (fifo_empty),
    .empty_next_c (fifo_empty_next)
  );

`ifdef PARPORT_ACK_EN
  logic ack_meta_q, ack_s_q, ack_prev_q;
  logic ack_seen_q, ack_seen_d;
  logic ack_fall;

  assign ack_fall = ack_prev_q & ~ack_s_q;
  assign ack_ok   = ack_seen_q;

  // Remember an ACK falling edge seen since the strobe finished
  always_comb begin
    ack_seen_d = ack_seen_q;
    if (state_q == ST_STROBE && state_d == ST_HOLD) ack_seen_d = 1'b0;
    if (ack_fall) ack_seen_d = 1'b1;
  end

  // ACK synchroniser, edge history and seen flag
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      ack_meta_q <= 1'b1;
      ack_s_q    <= 1'b1;
      ack_prev_q <= 1'b1;
      ack_seen_q <= 1'b0;
    end else begin
      ack_meta_q <= ack_n;
      ack_s_q    <= ack_meta_q;
      ack_prev_q <= ack_s_q;
      ack_seen_q <= ack_seen_d;
    end
  end
`else
  assign ack_ok = 1'b1;
`endif

  // Transfer sequencing, counters and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    err_d   = err_q & ~clr_err;
    pop_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty && !busy_s_q && !err_q) begin
          pop_c   = 1'b1;
          data_d  = fifo_rd;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = STROBE_LD;
          state_d = ST_STROBE;
        end else begin
          cnt_d = CW'(cnt_q - 1'b1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          cnt_d = CW'(cnt_q - 1'b1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          tmo_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = CW'(cnt_q - 1'b1);
        end
      end
      ST_WAIT: begin
        if (!busy_s_q && ack_ok) begin
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = TW'(tmo_q + 1'b1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    strobe_d = (state_d != ST_STROBE);
    oe_d     = enable || (state_d != ST_IDLE);
    idle_d   = (state_d == ST_IDLE) && fifo_empty_next;
  end

  // State, counters, BUSY synchroniser and output registers
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      data_q      <= '0;
      strobe_q    <= 1'b1;
      oe_q        <= 1'b0;
      idle_q      <= 1'b1;
      err_q       <= 1'b0;
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      oe_q        <= oe_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
      busy_meta_q <= busy_in;
      busy_s_q    <= busy_meta_q;
    end
  end

  assign wr_ready    = fifo_not_full;
  assign data_out    = data_q;
  assign data_oe     = oe_q;
  assign strobe_out  = strobe_q;
  assign strobe_oe   = oe_q;
  assign idle        = idle_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_parport_seq.sv
// Self-checking bench for parport_seq with a short timeout so the error path is reachable.
module tb_parport_seq;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned SETUP  = 16;
  localparam int unsigned STROBE = 32;
  localparam int unsigned HOLD   = 16;
  localparam int unsigned TMO    = 100;

  logic       clk32 = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [4:0] fifo_level;
  logic       busy_in = 1'b0;
  logic [7:0] data_out;
  logic       data_oe, strobe_out, strobe_oe, idle, timeout_err;
  logic       clr_err = 1'b0;
`ifdef PARPORT_ACK_EN
  logic       ack_n = 1'b1;
  bit         auto_ack = 1'b1;
`endif

  int errors = 0;
  int checks = 0;

  // Observed transfers: byte latched at each strobe fall, low width at each rise
  logic [7:0]  cap_q[$];
  int unsigned wid_q[$];
  int unsigned mon_cyc = 0;
  int unsigned low_start = 0;
  bit          low_valid = 1'b0;
  logic        mon_prev = 1'b1;

  parport_seq #(
    .FIFO_DEPTH  (DEPTH),
    .SETUP_CYC   (SETUP),
    .STROBE_CYC  (STROBE),
    .HOLD_CYC    (HOLD),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk32       (clk32),
    .reset_n     (reset_n),
    .enable      (enable),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .fifo_level  (fifo_level),
    .busy_in     (busy_in),
`ifdef PARPORT_ACK_EN
    .ack_n       (ack_n),
`endif
    .data_out    (data_out),
    .data_oe     (data_oe),
    .strobe_out  (strobe_out),
    .strobe_oe   (strobe_oe),
    .idle        (idle),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  always #5 clk32 = ~clk32;

  // Strobe monitor sampled on the falling clock edge
  always @(negedge clk32) begin
    mon_cyc++;
    if (!reset_n) begin
      mon_prev  = 1'b1;
      low_valid = 1'b0;
    end else begin
      if (mon_prev && !strobe_out) begin
        cap_q.push_back(data_out);
        low_start = mon_cyc;
        low_valid = 1'b1;
      end
      if (!mon_prev && strobe_out && low_valid) begin
        wid_q.push_back(mon_cyc - low_start);
        low_valid = 1'b0;
      end
      mon_prev = strobe_out;
    end
  end

`ifdef PARPORT_ACK_EN
  // Printer model: acknowledge each byte shortly after the strobe rises
  always begin
    @(posedge strobe_out);
    if (auto_ack && reset_n) begin
      repeat (2) @(posedge clk32);
      #1 ack_n = 1'b0;
      repeat (3) @(posedge clk32);
      #1 ack_n = 1'b1;
    end
  end
`endif

  task automatic step(input int n);
    repeat (n) @(posedge clk32);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    @(posedge clk32);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(3);
    checks++; if (data_out !== 8'h00)  begin errors++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    checks++; if (data_oe !== 1'b0)    begin errors++; $display("FAIL reset_data_oe got=%b exp=0", data_oe); end
    checks++; if (strobe_out !== 1'b1) begin errors++; $display("FAIL reset_strobe got=%b exp=1", strobe_out); end
    checks++; if (strobe_oe !== 1'b0)  begin errors++; $display("FAIL reset_strobe_oe got=%b exp=0", strobe_oe); end
    checks++; if (wr_ready !== 1'b1)   begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (idle !== 1'b1)       begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic test_single;
    int n;
    enable = 1'b1;
    step(2);
    cap_q.delete(); wid_q.delete();
    wr_byte(8'h41);
    n = 0;
    while (strobe_out === 1'b1 && n < 200) begin step(1); n++; end
    checks++; if (n != SETUP + 1) begin errors++; $display("FAIL single_setup_latency got=%0d exp=%0d", n, SETUP + 1); end
    checks++; if (data_out !== 8'h41) begin errors++; $display("FAIL single_data got=%h exp=41", data_out); end
    checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL single_data_oe got=%b exp=1", data_oe); end
    n = 0;
    while (strobe_out === 1'b0 && n < 200) begin step(1); n++; end
    checks++; if (n != STROBE) begin errors++; $display("FAIL single_strobe_width got=%0d exp=%0d", n, STROBE); end
    n = 0;
    while (idle !== 1'b1 && n < 200) begin step(1); n++; end
    checks++; if (n != HOLD + 1) begin errors++; $display("FAIL single_idle_after_rise got=%0d exp=%0d", n, HOLD + 1); end
    checks++; if (data_out !== 8'h41) begin errors++; $display("FAIL single_data_kept got=%h exp=41", data_out); end
  endtask

  task automatic test_fill;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int mc, n;
    enable = 1'b0;
    step(3);
    cap_q.delete(); wid_q.delete();
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL fill_oe_disabled got=%b exp=0", data_oe); end
    mc = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      wr_data  = b;
      wr_valid = 1'b1;
      @(posedge clk32);
      #1;
      if (mc < DEPTH) begin exp_q.push_back(b); mc++; end
    end
    wr_valid = 1'b0;
    step(1);
    checks++; if (fifo_level !== 5'(mc)) begin errors++; $display("FAIL fill_level got=%0d exp=%0d", fifo_level, mc); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fill_wr_ready got=%b exp=0", wr_ready); end
    checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL fill_no_send_disabled got=%0d exp=0", cap_q.size()); end
    enable = 1'b1;
    n = 0;
    while ((cap_q.size() < DEPTH || idle !== 1'b1) && n < 4000) begin step(1); n++; end
    checks++; if (cap_q.size() != DEPTH) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", cap_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL fill_order idx=%0d got=%h exp=%h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_busy;
    int n;
    cap_q.delete(); wid_q.delete();
    busy_in = 1'b1;
    step(4);
    wr_byte(8'h55);
    step(60);
    checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL busy_blocks got=%0d exp=0", cap_q.size()); end
    checks++; if (strobe_out !== 1'b1) begin errors++; $display("FAIL busy_strobe_high got=%b exp=1", strobe_out); end
    busy_in = 1'b0;
    n = 0;
    while (strobe_out === 1'b1 && n < 200) begin step(1); n++; end
    checks++; if (n != 2 + 1 + SETUP) begin errors++; $display("FAIL busy_release_latency got=%0d exp=%0d", n, 2 + 1 + SETUP); end
    checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL busy_data got=%h exp=55", data_out); end
    n = 0;
    while (idle !== 1'b1 && n < 300) begin step(1); n++; end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL busy_back_idle got=%b exp=1", idle); end
  endtask

  task automatic test_timeout;
    int n;
    cap_q.delete(); wid_q.delete();
    wr_byte(8'hA1);
    n = 0;
    while (strobe_out === 1'b1 && n < 200) begin step(1); n++; end
    busy_in = 1'b1;
    wr_byte(8'hB2);
    n = 0;
    while (strobe_out === 1'b0 && n < 200) begin step(1); n++; end
    n = 0;
    while (timeout_err !== 1'b1 && n < 400) begin step(1); n++; end
    checks++; if (n != HOLD + TMO) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", n, HOLD + TMO); end
    busy_in = 1'b0;
    step(150);
    checks++; if (cap_q.size() != 1) begin errors++; $display("FAIL timeout_blocks_next got=%0d exp=1", cap_q.size()); end
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL timeout_level got=%0d exp=1", fifo_level); end
    wr_byte(8'hC3);
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL timeout_accepts_write got=%0d exp=2", fifo_level); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err); end
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b exp=0", timeout_err); end
    n = 0;
    while ((cap_q.size() < 3 || idle !== 1'b1) && n < 600) begin step(1); n++; end
    checks++; if (cap_q.size() != 3) begin errors++; $display("FAIL timeout_resume_count got=%0d exp=3", cap_q.size()); end
    if (cap_q.size() == 3) begin
      checks++; if (cap_q[1] !== 8'hB2) begin errors++; $display("FAIL timeout_resume_b got=%h exp=b2", cap_q[1]); end
      checks++; if (cap_q[2] !== 8'hC3) begin errors++; $display("FAIL timeout_resume_c got=%h exp=c3", cap_q[2]); end
    end
  endtask

`ifdef PARPORT_ACK_EN
  task automatic test_ack;
    int n;
    auto_ack = 1'b0;
    wr_byte(8'h5A);
    n = 0;
    while (strobe_out === 1'b1 && n < 200) begin step(1); n++; end
    n = 0;
    while (strobe_out === 1'b0 && n < 200) begin step(1); n++; end
    step(60);
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL ack_waits got=%b exp=0", idle); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL ack_no_err got=%b exp=0", timeout_err); end
    ack_n = 1'b0;
    step(3);
    ack_n = 1'b1;
    n = 0;
    while (idle !== 1'b1 && n < 10) begin step(1); n++; end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL ack_release got=%b exp=1", idle); end
    auto_ack = 1'b1;
  endtask
`endif

  task automatic test_reset_mid;
    int n;
    wr_byte(8'h11);
    wr_byte(8'h22);
    wr_byte(8'h33);
    n = 0;
    while (strobe_out === 1'b1 && n < 200) begin step(1); n++; end
    step(5);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (strobe_out !== 1'b1) begin errors++; $display("FAIL rstmid_strobe got=%b exp=1", strobe_out); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL rstmid_data_oe got=%b exp=0", data_oe); end
    checks++; if (strobe_oe !== 1'b0) begin errors++; $display("FAIL rstmid_strobe_oe got=%b exp=0", strobe_oe); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rstmid_level got=%0d exp=0", fifo_level); end
    step(3);
    reset_n = 1'b1;
    cap_q.delete(); wid_q.delete();
    step(100);
    checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL rstmid_discard got=%0d exp=0", cap_q.size()); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle got=%b exp=1", idle); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", data_out); end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int n, g;
    localparam int N = 40;
    cap_q.delete(); wid_q.delete();
    for (int i = 0; i < N; i++) begin
      g = 0;
      while (wr_ready !== 1'b1 && g < 1000) begin step(1); g++; end
      b = 8'($urandom);
      wr_byte(b);
      exp_q.push_back(b);
      if ($urandom_range(3, 0) == 0) begin
        busy_in = 1'b1;
        step(int'($urandom_range(20, 1)));
        busy_in = 1'b0;
      end
      step(int'($urandom_range(5, 0)));
    end
    n = 0;
    while ((cap_q.size() < N || idle !== 1'b1) && n < N * 150) begin step(1); n++; end
    checks++; if (cap_q.size() != N) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", cap_q.size(), N); end
    for (int i = 0; i < N && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data idx=%0d got=%h exp=%h", i, cap_q[i], exp_q[i]); end
    end
    for (int i = 0; i < wid_q.size(); i++) begin
      checks++;
      if (wid_q[i] != STROBE) begin errors++; $display("FAIL rand_width idx=%0d got=%0d exp=%0d", i, wid_q[i], STROBE); end
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rand_no_err got=%b exp=0", timeout_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_busy();
`ifdef PARPORT_ACK_EN
    test_ack();
`endif
    test_timeout();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
